// File: rtl/gray_step_tracker.sv
// gray_step_tracker: decodes a Gray sample stream, validates single-bit steps, tracks direction, revolutions and errors
module gray_step_tracker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] G,
  input  logic             clr,
  output logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             dir,
  output logic             wrap,
  output logic             step_err,
  output logic             locked,
  output logic [CNT_W-1:0] rev_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  typedef enum logic [1:0] {EMPTY, LOCKED, FAULT} state_t;
  state_t state;
  logic [WIDTH-1:0] prev_g, bn, x;
  logic same, single, up, dn;
  always_comb begin
    bn[WIDTH-1] = G[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) bn[i] = bn[i+1] ^ G[i];
    x      = G ^ prev_g;
    same   = x == '0;
    single = !same && (x & (x - 1'b1)) == '0;
    up     = bn == WIDTH'(B + 1'b1);
    dn     = bn == WIDTH'(B - 1'b1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      prev_g    <= '0;
      B         <= '0;
      out_valid <= 1'b0;
      dir       <= 1'b0;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
      locked    <= 1'b0;
      rev_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      out_valid <= in_valid;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
      if (in_valid) begin
        prev_g <= G;
        B      <= bn;
        case (state)
          EMPTY: begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
          LOCKED: begin
            if (single && (up || dn)) begin
              dir <= up;
              // crossing between the top code and zero counts one revolution
              if ((up && B == '1) || (dn && B == '0)) begin
                wrap    <= 1'b1;
                rev_cnt <= up ? rev_cnt + 1'b1 : rev_cnt - 1'b1;
              end
            end else if (!same && !single) begin
              step_err <= 1'b1;
              err_cnt  <= err_cnt == '1 ? err_cnt : err_cnt + 1'b1;
              state    <= FAULT;
              locked   <= 1'b0;
            end
          end
          default: begin
            state  <= same ? LOCKED : FAULT;
            locked <= same;
          end
        endcase
      end
      if (clr) begin
        rev_cnt <= '0;
        err_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_gray_step_tracker.sv
// tb_gray_step_tracker: randomized and directed checks against an arithmetic reference model
module tb_gray_step_tracker;
  logic clk = 0, rst = 0, in_valid = 0, clr = 0;
  logic [3:0] G = 0, B;
  logic out_valid, dir, wrap, step_err, locked;
  logic [7:0] rev_cnt, err_cnt;
  int checks = 0, errors = 0;
  int m_st, m_prev, m_b, m_dir, m_rev, m_err, m_ov, m_wr, m_se;

  gray_step_tracker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .G(G), .clr(clr), .B(B),
    .out_valid(out_valid), .dir(dir), .wrap(wrap), .step_err(step_err),
    .locked(locked), .rev_cnt(rev_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int dec(int g);
    return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
  endfunction

  function automatic int enc(int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic logic [24:0] obs();
    return {B, out_valid, dir, wrap, step_err, locked, rev_cnt, err_cnt};
  endfunction

  function automatic logic [24:0] expv();
    return {4'(m_b), 1'(m_ov), 1'(m_dir), 1'(m_wr), 1'(m_se), 1'(m_st == 1), 8'(m_rev), 8'(m_err)};
  endfunction

  task automatic drive(input logic r, input logic v, input int g, input logic c);
    int nb, d;
    rst = r; in_valid = v; G = 4'(g); clr = c;
    @(posedge clk);
    if (r) begin
      m_st = 0; m_prev = 0; m_b = 0; m_dir = 0; m_rev = 0; m_err = 0; m_ov = 0; m_wr = 0; m_se = 0;
    end else begin
      m_ov = v; m_wr = 0; m_se = 0;
      if (v) begin
        nb = dec(g);
        d = $countones(4'(g ^ m_prev));
        if (m_st == 0) m_st = 1;
        else if (m_st == 1) begin
          if (d == 1 && ((nb - m_b) & 15) == 1) begin
            m_dir = 1;
            if (m_b == 15) begin m_wr = 1; m_rev = (m_rev + 1) & 255; end
          end else if (d == 1 && ((m_b - nb) & 15) == 1) begin
            m_dir = 0;
            if (m_b == 0) begin m_wr = 1; m_rev = (m_rev - 1) & 255; end
          end else if (d > 1) begin
            m_se = 1; m_st = 2;
            if (m_err < 255) m_err++;
          end
        end else if (d == 0) m_st = 1;
        m_prev = g; m_b = nb;
      end
      if (c) begin m_rev = 0; m_err = 0; end
    end
    #1;
    rst = 0; in_valid = 0; clr = 0;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0);
    drive(1, 1, 9, 1);
    checks++;
    if (obs() !== 25'd0) begin errors++; $display("FAIL reset got %h exp 0", obs()); end
    drive(0, 1, 0, 0);
    checks++;
    if (obs() !== expv() || !locked || !out_valid) begin errors++; $display("FAIL first_sample got %h exp %h", obs(), expv()); end
    drive(0, 0, 0, 0);
    checks++;
    if (obs() !== expv() || out_valid) begin errors++; $display("FAIL pulse_end got %h exp %h", obs(), expv()); end
  endtask

  task automatic test_up();
    int seq[5] = '{0, 1, 3, 2, 6};
    drive(1, 0, 0, 0);
    foreach (seq[i]) begin
      drive(0, 1, seq[i], 0);
      checks++;
      if (obs() !== expv() || B !== 4'(i) || (i > 0 && dir !== 1'b1)) begin
        errors++; $display("FAIL up_step%0d got %h exp %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_wrap();
    int seq[4] = '{8, 0, 8, 9};
    logic [24:0] lit[4];
    lit[0] = {4'd15, 5'b10001, 8'd0, 8'd0};
    lit[1] = {4'd0, 5'b11101, 8'd1, 8'd0};
    lit[2] = {4'd15, 5'b10101, 8'd0, 8'd0};
    lit[3] = {4'd14, 5'b10001, 8'd0, 8'd0};
    drive(1, 0, 0, 0);
    foreach (seq[i]) begin
      drive(0, 1, seq[i], 0);
      checks++;
      if (obs() !== lit[i] || obs() !== expv()) begin
        errors++; $display("FAIL wrap%0d got %h exp %h", i, obs(), lit[i]);
      end
    end
  endtask

  task automatic test_fault();
    int seq[5] = '{0, 3, 2, 2, 6};
    logic [24:0] lit[5];
    lit[0] = {4'd0, 5'b10001, 8'd0, 8'd0};
    lit[1] = {4'd2, 5'b10010, 8'd0, 8'd1};
    lit[2] = {4'd3, 5'b10000, 8'd0, 8'd1};
    lit[3] = {4'd3, 5'b10001, 8'd0, 8'd1};
    lit[4] = {4'd4, 5'b11001, 8'd0, 8'd1};
    drive(1, 0, 0, 0);
    foreach (seq[i]) begin
      drive(0, 1, seq[i], 0);
      checks++;
      if (obs() !== lit[i] || obs() !== expv()) begin
        errors++; $display("FAIL fault%0d got %h exp %h", i, obs(), lit[i]);
      end
    end
  endtask

  task automatic test_idle();
    logic [24:0] held;
    drive(0, 1, 7, 0);
    held = expv();
    held[20] = 1'b0;
    held[18:17] = 2'b00;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, $urandom_range(0, 15), 0);
      checks++;
      if (obs() !== held || obs() !== expv()) begin errors++; $display("FAIL idle%0d got %h exp %h", i, obs(), held); end
    end
  endtask

  task automatic test_saturate();
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 150; i++) begin
      drive(0, 1, 3, 0);
      drive(0, 1, 3, 0);
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
    end
    checks++;
    if (err_cnt !== 8'd255 || obs() !== expv()) begin errors++; $display("FAIL err_sat got %0d exp 255", err_cnt); end
    drive(0, 1, 3, 1);
    checks++;
    if (err_cnt !== 8'd0 || step_err !== 1'b1 || obs() !== expv()) begin
      errors++; $display("FAIL clr_wins got %h exp %h", obs(), expv());
    end
    drive(0, 1, 3, 0);
    drive(0, 1, 2, 0);
    drive(0, 1, 6, 0);
    drive(0, 0, 0, 1);
    checks++;
    if (err_cnt !== 8'd0 || rev_cnt !== 8'd0 || locked !== 1'b1 || obs() !== expv()) begin
      errors++; $display("FAIL clr got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_midreset();
    drive(0, 1, 4, 0);
    drive(1, 1, 4, 0);
    checks++;
    if (obs() !== 25'd0) begin errors++; $display("FAIL mid_rst got %h exp 0", obs()); end
    drive(0, 1, 5, 0);
    checks++;
    if (B !== 4'd6 || locked !== 1'b1 || step_err !== 1'b0 || obs() !== expv()) begin
      errors++; $display("FAIL after_rst got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    int g, k, bad = 0;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      k = $urandom_range(0, 19);
      if (k < 6) g = enc((m_b + 1) & 15);
      else if (k < 12) g = enc((m_b - 1) & 15);
      else if (k < 14) g = m_prev;
      else if (k < 17) begin
        do g = $urandom_range(0, 15); while ($countones(4'(g ^ m_prev)) < 2);
      end else g = $urandom_range(0, 15);
      drive(k == 19 && $urandom_range(0, 9) == 0, k != 18, g, $urandom_range(0, 49) == 0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        if (bad++ < 10) $display("FAIL random%0d got %h exp %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_wrap();
    test_fault();
    test_idle();
    test_saturate();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
